// File: rtl/jump_rs.sv
// jump_rs: reservation station in front of the non-pipelined jump/branch FU.
//
// Holds up to DEPTH decoded JAL/JALR/branch micro-ops. It captures missing
// source operands from the CDB and dispatches the oldest fully-ready entry as
// a one-cycle fu_en pulse with a registered operand bundle. After a dispatch,
// a cooldown counter keeps further pulses at least FU_LAT cycles apart.
//
// Optional build macro: JUMP_RS_WAKEUP_BYPASS_EN
//   When defined, an entry whose missing operand(s) match the current CDB
//   broadcast is dispatchable in the same cycle. In that case cdb_data is
//   forwarded straight into fu_rs1_data/fu_rs2_data.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   issue_*                 decode-side micro-op offer (valid/ready handshake)
//   cdb_valid/tag/data      common data bus broadcast
//   flush                   squash every buffered op (the FU cooldown keeps running)
//   fu_en                   one-cycle dispatch pulse
//   fu_*                    registered op bundle, held between dispatches
//   occupancy               number of valid entries
module jump_rs #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4,
    parameter int FU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_jalr,
    input  logic [2:0]       issue_cmp_ctrl,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [31:0]      issue_rs1_data,
    input  logic [31:0]      issue_rs2_data,
    input  logic             issue_rs1_rdy,
    input  logic             issue_rs2_rdy,
    input  logic [TAG_W-1:0] issue_rs1_tag,
    input  logic [TAG_W-1:0] issue_rs2_tag,
    input  logic [TAG_W-1:0] issue_rd_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             flush,
    output logic             fu_en,
    output logic             fu_jalr,
    output logic [2:0]       fu_cmp_ctrl,
    output logic [31:0]      fu_rs1_data,
    output logic [31:0]      fu_rs2_data,
    output logic [31:0]      fu_imm,
    output logic [31:0]      fu_pc,
    output logic [TAG_W-1:0] fu_rd_tag,
    output logic [2:0]       occupancy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RK_W  = 3;
    localparam int CD_W  = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    // Entry state
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rs1_rdy;
    logic [DEPTH-1:0] rs2_rdy;
    // rank = number of younger valid entries; the largest rank is the oldest
    logic [RK_W-1:0]  rank    [DEPTH];
    logic             jalr_q  [DEPTH];
    logic [2:0]       cmp_q   [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      rs1_q   [DEPTH];
    logic [31:0]      rs2_q   [DEPTH];
    logic [TAG_W-1:0] rs1_tag [DEPTH];
    logic [TAG_W-1:0] rs2_tag [DEPTH];
    logic [TAG_W-1:0] rd_q    [DEPTH];

    logic [CD_W-1:0]  cooldown;

    logic [DEPTH-1:0] hit1, hit2, cand;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [RK_W-1:0]  sel_rank;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_found;
    logic             alloc;
    logic             disp;
    logic [2:0]       cnt;
    logic             new_rs1_rdy, new_rs2_rdy;
    logic [31:0]      new_rs1_data, new_rs2_data;
    logic [31:0]      sel_rs1_data, sel_rs2_data;

    // CDB tag match per waiting operand, and the dispatch candidates
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = cdb_valid & ~rs1_rdy[i] & (rs1_tag[i] == cdb_tag);
            hit2[i] = cdb_valid & ~rs2_rdy[i] & (rs2_tag[i] == cdb_tag);
`ifdef JUMP_RS_WAKEUP_BYPASS_EN
            cand[i] = vld[i] & (rs1_rdy[i] | hit1[i]) & (rs2_rdy[i] | hit2[i]);
`else
            cand[i] = vld[i] & rs1_rdy[i] & rs2_rdy[i];
`endif
        end
    end

    // Oldest ready entry: the candidate with the highest rank
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && (!sel_found || rank[i] > sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = rank[i];
            end
        end
    end

    // Lowest-numbered free entry, plus the occupancy count
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        cnt         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + 3'(vld[i]);
            if (!vld[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    assign occupancy   = cnt;
    assign issue_ready = (cnt != 3'(DEPTH)) & ~flush;
    assign alloc       = issue_valid & issue_ready;
    assign disp        = sel_found & (cooldown == '0) & ~flush;

    // An operand that is missing at issue can still be caught from the CDB in the same cycle
    assign new_rs1_rdy  = issue_rs1_rdy | (cdb_valid & (issue_rs1_tag == cdb_tag));
    assign new_rs2_rdy  = issue_rs2_rdy | (cdb_valid & (issue_rs2_tag == cdb_tag));
    assign new_rs1_data = issue_rs1_rdy ? issue_rs1_data : cdb_data;
    assign new_rs2_data = issue_rs2_rdy ? issue_rs2_data : cdb_data;

`ifdef JUMP_RS_WAKEUP_BYPASS_EN
    assign sel_rs1_data = hit1[sel_idx] ? cdb_data : rs1_q[sel_idx];
    assign sel_rs2_data = hit2[sel_idx] ? cdb_data : rs2_q[sel_idx];
`else
    assign sel_rs1_data = rs1_q[sel_idx];
    assign sel_rs2_data = rs2_q[sel_idx];
`endif

    // Control state: valid bits, ranks, ready flags, cooldown, dispatch bundle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld         <= '0;
            cooldown    <= '0;
            fu_en       <= 1'b0;
            fu_jalr     <= 1'b0;
            fu_cmp_ctrl <= '0;
            fu_rs1_data <= '0;
            fu_rs2_data <= '0;
            fu_imm      <= '0;
            fu_pc       <= '0;
            fu_rd_tag   <= '0;
        end else begin
            fu_en <= disp;
            if (disp)
                cooldown <= CD_W'(FU_LAT - 1);
            else if (cooldown != '0)
                cooldown <= cooldown - CD_W'(1);

            if (disp) begin
                fu_jalr     <= jalr_q[sel_idx];
                fu_cmp_ctrl <= cmp_q[sel_idx];
                fu_rs1_data <= sel_rs1_data;
                fu_rs2_data <= sel_rs2_data;
                fu_imm      <= imm_q[sel_idx];
                fu_pc       <= pc_q[sel_idx];
                fu_rd_tag   <= rd_q[sel_idx];
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    vld[i] <= 1'b0;
                end else if (disp && sel_idx == IDX_W'(i)) begin
                    vld[i] <= 1'b0;
                end else if (vld[i]) begin
                    // A new arrival makes everyone older; freeing a younger entry brings older ones closer
                    rank[i] <= rank[i] + RK_W'(alloc) - RK_W'(disp && (rank[i] > sel_rank));
                    if (hit1[i]) rs1_rdy[i] <= 1'b1;
                    if (hit2[i]) rs2_rdy[i] <= 1'b1;
                end else if (alloc && alloc_idx == IDX_W'(i)) begin
                    vld[i]     <= 1'b1;
                    rank[i]    <= '0;
                    rs1_rdy[i] <= new_rs1_rdy;
                    rs2_rdy[i] <= new_rs2_rdy;
                end
            end
        end
    end

    // Entry payload: no reset needed, qualified by the valid/ready flags
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && alloc_idx == IDX_W'(i)) begin
                jalr_q[i]  <= issue_jalr;
                cmp_q[i]   <= issue_cmp_ctrl;
                imm_q[i]   <= issue_imm;
                pc_q[i]    <= issue_pc;
                rs1_q[i]   <= new_rs1_data;
                rs2_q[i]   <= new_rs2_data;
                rs1_tag[i] <= issue_rs1_tag;
                rs2_tag[i] <= issue_rs2_tag;
                rd_q[i]    <= issue_rd_tag;
            end else begin
                if (hit1[i]) rs1_q[i] <= cdb_data;
                if (hit2[i]) rs2_q[i] <= cdb_data;
            end
        end
    end

endmodule
